// File: rtl/riscv_pkg.sv
// Shared core constants and the layout of one instruction-buffer entry.
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// The head is read straight out of flops, so it has no combinational path from push.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = FETCH_ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-gated memory requests and buffers
// returned instructions for decode; redirects flush and drop in-flight responses.
module fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = XLEN + 32;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_dec;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            run;
    logic            req_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;

    // Requests in flight plus buffered entries never exceed the buffer size,
    // so every response always has a slot waiting for it.
    assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign o_imem_req_valid = run && !i_redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign outstanding_dec     = outstanding - CW'(i_imem_rsp_valid);
    assign redirect_pc_aligned = i_redirect_pc & ~XLEN'(3);

    assign fifo_push = i_imem_rsp_valid && !i_redirect && (discard == '0);
    assign fifo_pop  = o_instr_valid && i_instr_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_dec + CW'(req_fire);
            if (i_redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_pc_aligned;
                rsp_pc   <= redirect_pc_aligned;
                discard  <= outstanding_dec;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (fifo_push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (i_imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (fifo_push),
        .push_data ({rsp_pc, i_imem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (i_redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign o_instr_valid = !fifo_empty;
    assign o_instr       = fifo_head[31:0];
    assign o_instr_pc    = fifo_head[EW-1:32];

    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(fifo_push && fifo_full && !fifo_pop));

    a_counters : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (discard <= outstanding) && (outstanding <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with word(addr) = addr + 0x100,
// and an in-order scoreboard of expected {pc, instr} pairs.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .o_instr_valid    (instr_valid),
        .i_instr_ready    (instr_ready),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_acc, n_rsp, n_pop;
    int           first_acc, first_pop;
    int           cyc = 0;
    int           last_due = 0;
    int           mem_lat = 1;
    bit           mem_rand = 0;
    logic [31:0]  exp_fetch;
    logic [31:0]  last_acc_addr;
    logic [31:0]  prev_pc, prev_instr, prev_addr;
    bit           prev_stall, prev_req_wait;
    fetch_entry_t sb[$];
    int           mq_due[$];
    logic [31:0]  mq_addr[$];
    logic [31:0]  since[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; holds reset for n clock edges and returns at posedge+1.
    task automatic pulse_reset(input int n);
        reset_n   = 1'b0;
        n_acc     = 0;
        n_rsp     = 0;
        n_pop     = 0;
        first_acc = -1;
        first_pop = -1;
        repeat (n) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_outs(input string pfx);
        @(negedge clk);
        check_eq({pfx, "_req_valid"}, imem_req_valid, 0);
        check_eq({pfx, "_instr_valid"}, instr_valid, 0);
        check_eq({pfx, "_instr"}, instr, 0);
        check_eq({pfx, "_instr_pc"}, instr_pc, 0);
    endtask

    // Memory response driver: in-order, fixed or random latency.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mq_due.size() > 0 && mq_due[0] == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq_addr[0] + 32'h100;
                void'(mq_due.pop_front());
                void'(mq_addr.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    initial begin
        fetch_entry_t e;
        int           due;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mq_due.delete();
                mq_addr.delete();
                sb.delete();
                since.delete();
                exp_fetch     = RESET_PC;
                last_due      = 0;
                prev_stall    = 0;
                prev_req_wait = 0;
            end else begin
                if (prev_req_wait && !redirect) begin
                    check_eq("req_hold_valid", imem_req_valid, 1);
                    check_eq("req_hold_addr", imem_req_addr, prev_addr);
                end
                if (prev_stall) begin
                    check_eq("out_hold_valid", instr_valid, 1);
                    check_eq("out_hold_pc", instr_pc, prev_pc);
                    check_eq("out_hold_instr", instr, prev_instr);
                end
                if (instr_valid && instr_ready) begin
                    n_pop++;
                    if (first_pop < 0) first_pop = cyc;
                    since.push_back(instr_pc);
                    if (sb.size() == 0) begin
                        check_eq("pop_unexpected_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check_eq("pop_pc", instr_pc, e.pc);
                        check_eq("pop_instr", instr, e.instr);
                    end
                end
                prev_stall    = instr_valid && !instr_ready;
                prev_pc       = instr_pc;
                prev_instr    = instr;
                prev_req_wait = imem_req_valid && !imem_req_ready;
                prev_addr     = imem_req_addr;
                if (redirect) begin
                    check_eq("redir_req_gated", imem_req_valid, 0);
                    sb.delete();
                    since.delete();
                    exp_fetch     = redirect_pc & ~32'h3;
                    prev_stall    = 0;
                    prev_req_wait = 0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    check_eq("req_addr", imem_req_addr, exp_fetch);
                    e.pc    = exp_fetch;
                    e.instr = exp_fetch + 32'h100;
                    sb.push_back(e);
                    exp_fetch = exp_fetch + 32'h4;
                    due = cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mq_due.push_back(due);
                    mq_addr.push_back(imem_req_addr);
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc_addr = imem_req_addr;
                end
                if (imem_rsp_valid) n_rsp++;
            end
        end
    end

    initial begin
        int p0;
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with 1-cycle memory and decode always ready.
        pulse_reset(3);
        check_reset_outs("rst");
        repeat (20) @(posedge clk);
        #1;
        check_eq("t1_startup", first_pop - first_acc, 2);
        p0 = n_pop;
        repeat (16) @(posedge clk);
        #1;
        check_eq("t1_throughput", n_pop - p0, 16);

        // Decode stalled: credit runs out after four requests.
        instr_ready = 1'b0;
        pulse_reset(2);
        check_reset_outs("t2_rst");
        repeat (12) @(posedge clk);
        #1;
        check_eq("t2_accepts", n_acc, 4);
        @(negedge clk);
        check_eq("t2_req_valid_low", imem_req_valid, 0);
        check_eq("t2_head_valid", instr_valid, 1);
        check_eq("t2_head_pc", instr_pc, 0);
        check_eq("t2_head_instr", instr, 32'h100);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t2_resume_addr", last_acc_addr, 32'h10);
        for (int i = 0; i < 20 && n_pop < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t2_drained", n_pop >= 4, 1);

        // Latency 3, redirect with two requests in flight.
        mem_lat = 3;
        pulse_reset(1);
        check_reset_outs("t3_rst");
        for (int i = 0; i < 20 && n_acc < 2; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t3_two_acc", n_acc, 2);
        check_eq("t3_in_flight", n_acc - n_rsp, 2);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(posedge clk);
        #1 redirect = 1'b0;
        for (int i = 0; i < 40 && since.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t3_pops", since.size() >= 2, 1);
        if (since.size() >= 2) begin
            check_eq("t3_first_pc", since[0], 32'h200);
            check_eq("t3_second_pc", since[1], 32'h204);
        end

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check_eq("t4_req_valid", imem_req_valid, 1);
        check_eq("t4_req_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 40 && since.size() < 1; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t4_pops", since.size() >= 1, 1);
        if (since.size() >= 1) check_eq("t4_first_pc", since[0], 32'h200);

        // Redirect coinciding with a handshake and a response; target wraps past 2^32.
        mem_lat = 1;
        repeat (10) @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        check_eq("t5_handshake", instr_valid && instr_ready, 1);
        check_eq("t5_rsp_arrives", imem_rsp_valid, 1);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check_eq("t5_valid_next", instr_valid, 0);
        for (int i = 0; i < 40 && since.size() < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t5_pops", since.size() >= 3, 1);
        if (since.size() >= 3) begin
            check_eq("t5_pc0", since[0], 32'hFFFF_FFF8);
            check_eq("t5_pc1", since[1], 32'hFFFF_FFFC);
            check_eq("t5_pc_wrap", since[2], 32'h0);
        end

        // One-cycle reset mid-stream with three requests outstanding.
        mem_lat = 3;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 10 && (n_acc - n_rsp) != 3; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_in_flight", n_acc - n_rsp, 3);
        pulse_reset(1);
        check_reset_outs("t6_rst");
        for (int i = 0; i < 10 && n_acc < 1; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_first_addr", last_acc_addr, 32'h0);
        repeat (20) @(posedge clk);
        #1;

        // Random backpressure, latencies and redirects (including back-to-back).
        mem_rand = 1;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFF);
            end else begin
                redirect = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        redirect    = 1'b0;
        instr_ready = 1'b1;
        mem_rand    = 0;
        mem_lat     = 1;
        p0 = n_pop;
        repeat (30) @(posedge clk);
        #1;
        check_eq("t7_still_flowing", n_pop - p0 > 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
